// File: rtl/fmac_arb_pkg.sv
// Shared types and constants for the two-channel FMAC arbiter.
// State encodings, timeout default and bus field widths.
package fmac_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam int TIMEOUT_DEF = 16;
  localparam int COEF_W      = 16;
  localparam int OPND_W      = 11;
  localparam int COEF_BUS_W  = 8 * COEF_W;
  localparam int OPND_BUS_W  = 8 * OPND_W;
  localparam int SE_W        = 15;

endpackage

// File: rtl/fmac_rr_arb.sv
// Two-way round-robin arbiter.
// On a tie the channel not served last wins.
module fmac_rr_arb (
  input  logic [1:0] elig,
  input  logic       last,
  output logic       gnt
);

  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      (elig == 2'b11): gnt = ~last;
      (elig == 2'b10): gnt = 1'b1;
      default:         gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/fmac_arb.sv
// Arbitrates two requesters onto one shared multiply-accumulate unit.
// One transaction in flight; results returned per channel with an ACK pulse.
module fmac_arb
  import fmac_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic [COEF_BUS_W-1:0] COEF0,
  input  logic [COEF_BUS_W-1:0] COEF1,
  input  logic [OPND_BUS_W-1:0] OPND0,
  input  logic [OPND_BUS_W-1:0] OPND1,
  output logic                  ACK0,
  output logic                  ACK1,
  output logic [SE_W-1:0]       SE0,
  output logic [SE_W-1:0]       SEZ0,
  output logic [SE_W-1:0]       SE1,
  output logic [SE_W-1:0]       SEZ1,
  output logic                  ERR,
  output logic                  FMA_START,
  output logic [COEF_BUS_W-1:0] FMA_COEF,
  output logic [OPND_BUS_W-1:0] FMA_OPND,
  input  logic                  FMA_DONE,
  input  logic [SE_W-1:0]       FMA_SE,
  input  logic [SE_W-1:0]       FMA_SEZ
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  state_t        nxt;
  logic          gnt;
  logic          last;
  logic          arb_gnt;
  logic [1:0]    ack;
  logic [1:0]    elig;
  logic [CW-1:0] cnt;
  logic          timeout;

  // A channel being acked this cycle must not be re-granted at once.
  assign elig    = {REQ1, REQ0} & ~ack;
  assign timeout = (state == BUSY) && !FMA_DONE
                && (cnt == CW'(TIMEOUT - 1));

  fmac_rr_arb u_rr (
    .elig (elig),
    .last (last),
    .gnt  (arb_gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (|elig) nxt = GRANT;
      GRANT:   nxt = BUSY;
      BUSY: begin
        if (FMA_DONE)     nxt = CAPTURE;
        else if (timeout) nxt = IDLE;
      end
      CAPTURE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt  <= 1'b0;
      last <= 1'b1;
      cnt  <= '0;
      ERR  <= 1'b0;
      ack  <= '0;
      SE0  <= '0;
      SEZ0 <= '0;
      SE1  <= '0;
      SEZ1 <= '0;
    end else begin
      ack <= '0;
      if (state == IDLE && |elig) gnt <= arb_gnt;
      if (state == GRANT)
        cnt <= '0;
      else if (state == BUSY && !FMA_DONE)
        cnt <= cnt + 1'b1;
      if (timeout) begin
        ERR      <= 1'b1;
        ack[gnt] <= 1'b1;
        last     <= gnt;
      end
      if (state == CAPTURE) begin
        ack[gnt] <= 1'b1;
        last     <= gnt;
        if (gnt) begin
          SE1  <= FMA_SE;
          SEZ1 <= FMA_SEZ;
        end else begin
          SE0  <= FMA_SE;
          SEZ0 <= FMA_SEZ;
        end
      end
    end
  end

  always_comb begin
    FMA_START = (state == GRANT);
    FMA_COEF  = '0;
    FMA_OPND  = '0;
    if (state != IDLE) begin
      FMA_COEF = gnt ? COEF1 : COEF0;
      FMA_OPND = gnt ? OPND1 : OPND0;
    end
    ACK0 = ack[0];
    ACK1 = ack[1];
  end

endmodule

// File: tb/tb_fmac_arb.sv
// Directed bench for fmac_arb with a behavioural FMA unit model.
// Cycle tables plus hand sequences for timeout and mid-transaction reset.
module tb_fmac_arb;

  localparam logic [127:0] K_C0 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] K_C1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [87:0]  K_O0 = 88'h00_1122_3344_5566_7788_99aa;
  localparam logic [87:0]  K_O1 = 88'h7f_eedd_ccbb_aa99_8877_6655;
  localparam logic [14:0]  K_SE  = 15'h1234;
  localparam logic [14:0]  K_SEZ = 15'h0567;

  logic clk = 1'b0;
  logic reset;
  logic REQ0, REQ1;
  logic [127:0] COEF0, COEF1;
  logic [87:0]  OPND0, OPND1;
  logic ACK0, ACK1, ERR, FMA_START, FMA_DONE;
  logic [14:0] SE0, SEZ0, SE1, SEZ1, FMA_SE, FMA_SEZ;
  logic [127:0] FMA_COEF;
  logic [87:0]  FMA_OPND;

  int checks = 0;
  int errors = 0;
  logic hang = 1'b0;

  always #5 clk = ~clk;

  fmac_arb dut (
    .clk(clk), .reset(reset),
    .REQ0(REQ0), .REQ1(REQ1),
    .COEF0(COEF0), .COEF1(COEF1),
    .OPND0(OPND0), .OPND1(OPND1),
    .ACK0(ACK0), .ACK1(ACK1),
    .SE0(SE0), .SEZ0(SEZ0), .SE1(SE1), .SEZ1(SEZ1),
    .ERR(ERR), .FMA_START(FMA_START),
    .FMA_COEF(FMA_COEF), .FMA_OPND(FMA_OPND),
    .FMA_DONE(FMA_DONE), .FMA_SE(FMA_SE), .FMA_SEZ(FMA_SEZ)
  );

  // Unit model: DONE 8 cycles after START, results registered on DONE.
  logic [3:0] m_cnt;
  logic       m_zero;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt    <= '0;
      m_zero   <= 1'b0;
      FMA_DONE <= 1'b0;
      FMA_SE   <= '0;
      FMA_SEZ  <= '0;
    end else begin
      FMA_DONE <= 1'b0;
      if (FMA_START) begin
        m_cnt  <= 4'd7;
        m_zero <= (FMA_COEF == '0) && (FMA_OPND == '0);
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1'b1;
        if (m_cnt == 1 && !hang) FMA_DONE <= 1'b1;
      end
      if (FMA_DONE) begin
        FMA_SE  <= m_zero ? 15'h0 : K_SE;
        FMA_SEZ <= m_zero ? 15'h0 : K_SEZ;
      end
    end
  end

  typedef struct packed {
    logic       req0;
    logic       req1;
    logic       start;
    logic       ack0;
    logic       ack1;
    logic [1:0] sel;
  } vec_t;

  vec_t tbl [0:39];
  int   tlen;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_tbl(input int len);
    tlen = len;
    for (int i = 0; i < 40; i++) tbl[i] = '0;
  endtask

  task automatic set_req(input int ch, input int from, input int to);
    for (int i = from; i <= to; i++)
      if (ch == 0) tbl[i].req0 = 1'b1;
      else         tbl[i].req1 = 1'b1;
  endtask

  // Grant at cycle g: START at g, bus selected g..g+9, ACK at g+10.
  task automatic mark(input int ch, input int g);
    tbl[g].start = 1'b1;
    for (int i = g; i <= g + 9; i++) tbl[i].sel = 2'(ch + 1);
    if (ch == 0) tbl[g + 10].ack0 = 1'b1;
    else         tbl[g + 10].ack1 = 1'b1;
  endtask

  task automatic do_reset;
    REQ0  = 1'b0;
    REQ1  = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_table(input string tag);
    logic [127:0] ec;
    logic [87:0]  eo;
    for (int i = 0; i < tlen; i++) begin
      REQ0 = tbl[i].req0;
      REQ1 = tbl[i].req1;
      @(negedge clk);
      ec = tbl[i].sel == 2'd1 ? K_C0 : tbl[i].sel == 2'd2 ? K_C1 : '0;
      eo = tbl[i].sel == 2'd1 ? K_O0 : tbl[i].sel == 2'd2 ? K_O1 : '0;
      chk($sformatf("%s c%0d start", tag, i), 128'(FMA_START),
          128'(tbl[i].start));
      chk($sformatf("%s c%0d ack0", tag, i), 128'(ACK0), 128'(tbl[i].ack0));
      chk($sformatf("%s c%0d ack1", tag, i), 128'(ACK1), 128'(tbl[i].ack1));
      chk($sformatf("%s c%0d coef", tag, i), FMA_COEF, ec);
      chk($sformatf("%s c%0d opnd", tag, i), 128'(FMA_OPND), 128'(eo));
      if (tbl[i].ack0) begin
        chk($sformatf("%s c%0d se0", tag, i), 128'(SE0), 128'(K_SE));
        chk($sformatf("%s c%0d sez0", tag, i), 128'(SEZ0), 128'(K_SEZ));
      end
      if (tbl[i].ack1) begin
        chk($sformatf("%s c%0d se1", tag, i), 128'(SE1), 128'(K_SE));
        chk($sformatf("%s c%0d sez1", tag, i), 128'(SEZ1), 128'(K_SEZ));
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Returns the cycle of ACKch counted from the caller's current cycle.
  task automatic wait_ack(input int ch, output int n);
    n = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((ch == 0 && ACK0) || (ch == 1 && ACK1)) begin
        n = k;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  int n;

  initial begin
    COEF0 = K_C0;
    COEF1 = K_C1;
    OPND0 = K_O0;
    OPND1 = K_O1;
    do_reset();
    chk("rst ack0", 128'(ACK0), 128'(0));
    chk("rst ack1", 128'(ACK1), 128'(0));
    chk("rst err", 128'(ERR), 128'(0));
    chk("rst start", 128'(FMA_START), 128'(0));
    chk("rst coef", FMA_COEF, 128'(0));
    chk("rst se", 128'({SE0, SEZ0, SE1, SEZ1}), 128'(0));

    // Single channel-0 transaction, REQ0 held through its ACK.
    clear_tbl(13);
    set_req(0, 0, 11);
    mark(0, 1);
    run_table("single");
    chk("single se1", 128'(SE1), 128'(0));
    chk("single sez1", 128'(SEZ1), 128'(0));

    // Both requesting from reset: ch0, ch1, ch0.
    do_reset();
    clear_tbl(34);
    set_req(0, 0, 33);
    set_req(1, 0, 33);
    mark(0, 1);
    mark(1, 12);
    mark(0, 23);
    run_table("both");

    // REQ1 held across its ACK, REQ0 arriving at c5 is next.
    do_reset();
    clear_tbl(24);
    set_req(1, 0, 11);
    set_req(0, 5, 22);
    mark(1, 1);
    mark(0, 12);
    run_table("hold");

    // Unit never finishes: timeout after 16 BUSY cycles.
    hang = 1'b1;
    do_reset();
    REQ0 = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    @(negedge clk);
    chk("to c17 ack0", 128'(ACK0), 128'(0));
    chk("to c17 err", 128'(ERR), 128'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("to c18 ack0", 128'(ACK0), 128'(1));
    chk("to c18 err", 128'(ERR), 128'(1));
    chk("to se0", 128'({SE0, SEZ0}), 128'(0));
    @(posedge clk);
    #1 REQ0 = 1'b0;
    hang = 1'b0;
    @(posedge clk);
    #1 REQ0 = 1'b1;
    wait_ack(0, n);
    chk("to next lat", 128'(n), 128'(11));
    chk("to next err", 128'(ERR), 128'(1));
    chk("to next se0", 128'(SE0), 128'(K_SE));
    @(posedge clk);
    #1 REQ0 = 1'b0;

    // Reset in c5 of a ch0 transaction.
    do_reset();
    REQ0 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid busy coef", FMA_COEF, K_C0);
    reset = 1'b1;
    #1;
    chk("mid rst coef", FMA_COEF, 128'(0));
    chk("mid rst opnd", 128'(FMA_OPND), 128'(0));
    chk("mid rst acks", 128'({ACK0, ACK1, FMA_START, ERR}), 128'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    wait_ack(0, n);
    chk("mid new lat", 128'(n), 128'(11));
    chk("mid new se0", 128'(SE0), 128'(K_SE));

    // All-zero operands give a zero result.
    @(posedge clk);
    #1 REQ0 = 1'b0;
    COEF0 = '0;
    OPND0 = '0;
    @(posedge clk);
    #1 REQ0 = 1'b1;
    wait_ack(0, n);
    chk("zero lat", 128'(n), 128'(11));
    chk("zero se0", 128'(SE0), 128'(0));
    chk("zero sez0", 128'(SEZ0), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
